// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, FSM states and
// datapath select codes.
package mc_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExecute, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
  } state_e;

  // AluOpNone parks alucontrol at 000 in states that do not use the ALU.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpNone  = 2'b11;

  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  localparam logic [1:0] SrcBRegB  = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
  } ctl_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: ALUOp plus funct to alucontrol, with a strobe for unsupported funct codes.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = AluCtlAnd;
    bad_funct  = 1'b0;
    case (aluop)
      AluOpAdd: alucontrol = AluCtlAdd;
      AluOpSub: alucontrol = AluCtlSub;
      AluOpFunct: begin
        case (funct)
          FnAdd:   alucontrol = AluCtlAdd;
          FnSub:   alucontrol = AluCtlSub;
          FnAnd:   alucontrol = AluCtlAnd;
          FnOr:    alucontrol = AluCtlOr;
          FnSlt:   alucontrol = AluCtlSlt;
          default: begin
            alucontrol = AluCtlAdd;
            bad_funct  = 1'b1;
          end
        endcase
      end
      default: alucontrol = AluCtlAnd;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with retired-instruction counter and sticky illegal flag.
// Optional bne support is enabled by defining MC_CONTROL_BNE_EN.
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        IRwrite,
  output logic        PCwrite,
  output logic        PCwritecond,
  output logic        IorD,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [2:0]  alucontrol,
  output logic        branch_ne,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic        illegal_q;
  logic [31:0] instret_q;
  ctl_t        ctl, ctl_out;
  logic [1:0]  aluop;
  logic [2:0]  alucontrol_raw;
  logic        bad_funct, bad_opcode, retire;
  logic        branch_ne_raw;

  always_comb begin
    state_d    = state_q;
    ctl        = '0;
    aluop      = AluOpNone;
    retire     = 1'b0;
    bad_opcode = 1'b0;
    case (state_q)
      StFetch: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = 1'b1;
        ctl.alu_src_b = SrcBFour;
        ctl.pc_write  = 1'b1;
        aluop         = AluOpAdd;
        state_d       = StDecode;
      end
      StDecode: begin
        ctl.alu_src_b = SrcBImmSh;
        aluop         = AluOpAdd;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
`ifdef MC_CONTROL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d    = StFetch;
            bad_opcode = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SrcBImm;
        aluop         = AluOpAdd;
        state_d       = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        state_d      = StMemWb;
      end
      StMemWb: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_d        = StFetch;
        retire         = 1'b1;
      end
      StMemWr: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StExecute: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SrcBRegB;
        aluop         = AluOpFunct;
        state_d       = StAluWb;
      end
      StAluWb: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StBranch: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SrcBRegB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_src        = PcSrcAluOut;
        aluop             = AluOpSub;
        state_d           = StFetch;
        retire            = 1'b1;
      end
      StAddiEx: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SrcBImm;
        aluop         = AluOpAdd;
        state_d       = StAddiWb;
      end
      StAddiWb: begin
        ctl.reg_write = 1'b1;
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StJump: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = PcSrcJump;
        state_d      = StFetch;
        retire       = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol_raw),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (bad_opcode || bad_funct) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

`ifdef MC_CONTROL_BNE_EN
  // Remember at decode whether the branch is bne so BRANCH stays a pure state output.
  logic bne_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bne_q <= 1'b0;
    end else if (state_q == StDecode) begin
      bne_q <= (opcode == OpBne);
    end
  end
  assign branch_ne_raw = (state_q == StBranch) && bne_q;
`else
  assign branch_ne_raw = 1'b0;
`endif

  // Outputs are forced low while reset is held, independent of the clock.
  assign ctl_out     = rst_n ? ctl : '0;
  assign IRwrite     = ctl_out.ir_write;
  assign PCwrite     = ctl_out.pc_write;
  assign PCwritecond = ctl_out.pc_write_cond;
  assign IorD        = ctl_out.iord;
  assign MemWrite    = ctl_out.mem_write;
  assign MemRead     = ctl_out.mem_read;
  assign RegWrite    = ctl_out.reg_write;
  assign RegDst      = ctl_out.reg_dst;
  assign MemtoReg    = ctl_out.mem_to_reg;
  assign ALUSrcA     = ctl_out.alu_src_a;
  assign ALUSrcB     = ctl_out.alu_src_b;
  assign PCSrc       = ctl_out.pc_src;
  assign alucontrol  = rst_n ? alucontrol_raw : 3'b000;
  assign branch_ne   = rst_n & branch_ne_raw;
  assign illegal     = illegal_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: instruction table, random instruction stream, reset
// and counter-wrap sequences, all checked against a per-instruction-phase reference model.
`timescale 1ns/1ps
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        IRwrite, PCwrite, PCwritecond, IorD, MemWrite, MemRead;
  logic        RegWrite, RegDst, MemtoReg, ALUSrcA, branch_ne, illegal;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  alucontrol;
  logic [31:0] instret;

  always #5 clk = ~clk;

  mc_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .IRwrite     (IRwrite),
    .PCwrite     (PCwrite),
    .PCwritecond (PCwritecond),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSrc       (PCSrc),
    .alucontrol  (alucontrol),
    .branch_ne   (branch_ne),
    .illegal     (illegal),
    .instret     (instret)
  );

`ifdef MC_CONTROL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  typedef struct packed {
    logic irw, pcw, pcwc, iord, memw, memr, regw, regdst, m2r, srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       bne;
  } ctl_t;

  ctl_t act;
  assign act = {IRwrite, PCwrite, PCwritecond, IorD, MemWrite, MemRead, RegWrite, RegDst,
                MemtoReg, ALUSrcA, ALUSrcB, PCSrc, alucontrol, branch_ne};

  int          checks = 0;
  int          errors = 0;
  logic        illegal_m = 1'b0;
  logic [31:0] instret_m = 32'd0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
           op == 6'b001000 || op == 6'b000010 || (BneEn && op == 6'b000101);
  endfunction

  function automatic int inst_len(input logic [5:0] op);
    if (!op_legal(op)) return 2;
    case (op)
      6'b100011:                       return 5;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default:                         return 4;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 ||
           f == 6'b101010;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control word for cycle k (0 = fetch) of the instruction with opcode op.
  function automatic ctl_t expect_ctl(input logic [5:0] op, input logic [5:0] f, input int k);
    ctl_t c = '0;
    if (k == 0) begin
      c.memr = 1; c.irw = 1; c.srcb = 2'd1; c.aluc = 3'b010; c.pcw = 1;
    end else if (k == 1) begin
      c.srcb = 2'd3; c.aluc = 3'b010;
    end else if (op == 6'b100011 || op == 6'b101011) begin
      if (k == 2) begin c.srca = 1; c.srcb = 2'd2; c.aluc = 3'b010; end
      else if (op == 6'b100011 && k == 3) begin c.memr = 1; c.iord = 1; end
      else if (op == 6'b100011 && k == 4) begin c.regw = 1; c.m2r = 1; end
      else if (op == 6'b101011 && k == 3) begin c.memw = 1; c.iord = 1; end
    end else if (op == 6'b000000) begin
      if (k == 2) begin c.srca = 1; c.aluc = funct_alu(f); end
      else if (k == 3) begin c.regw = 1; c.regdst = 1; end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      c.srca = 1; c.aluc = 3'b110; c.pcwc = 1; c.pcsrc = 2'd1; c.bne = (op == 6'b000101);
    end else if (op == 6'b001000) begin
      if (k == 2) begin c.srca = 1; c.srcb = 2'd2; c.aluc = 3'b010; end
      else if (k == 3) c.regw = 1;
    end else if (op == 6'b000010) begin
      c.pcw = 1; c.pcsrc = 2'd2;
    end
    return c;
  endfunction

  // Called at a falling edge with the DUT in FETCH; returns at the falling edge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int len);
    opcode = op;
    funct  = f;
    for (int k = 0; k < len; k++) begin
      #1;
      check($sformatf("ctl op=%b f=%b cyc=%0d", op, f, k), 32'(act), 32'(expect_ctl(op, f, k)));
      @(negedge clk);
    end
    if (!op_legal(op)) begin
      illegal_m = 1'b1;
    end else begin
      if (op == 6'b000000 && !funct_ok(f)) illegal_m = 1'b1;
      instret_m = instret_m + 32'd1;
    end
    check($sformatf("illegal op=%b", op), 32'(illegal), 32'(illegal_m));
    check($sformatf("instret op=%b", op), instret, instret_m);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] f;
    int         cycles;
  } vec_t;

  vec_t        tbl[14];
  logic [5:0]  ops[8];

  initial begin
    tbl[0]  = '{6'b100011, 6'b000000, 5};
    tbl[1]  = '{6'b000000, 6'b101010, 4};
    tbl[2]  = '{6'b000100, 6'b000000, 3};
    tbl[3]  = '{6'b000010, 6'b000000, 3};
    tbl[4]  = '{6'b101011, 6'b000000, 4};
    tbl[5]  = '{6'b001000, 6'b000000, 4};
    tbl[6]  = '{6'b000000, 6'b100000, 4};
    tbl[7]  = '{6'b000000, 6'b100010, 4};
    tbl[8]  = '{6'b000000, 6'b100100, 4};
    tbl[9]  = '{6'b000000, 6'b100101, 4};
    tbl[10] = '{6'b111111, 6'b000000, 2};
    tbl[11] = '{6'b100011, 6'b000000, 5};
    tbl[12] = '{6'b000101, 6'b000000, BneEn ? 3 : 2};
    tbl[13] = '{6'b000000, 6'b000001, 4};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010,
            6'b111111};

    // Reset held: everything low regardless of clock.
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", 32'(act), 32'd0);
    check("reset instret", instret, 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].f, tbl[i].cycles);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [5:0] f;
      op = ops[$urandom_range(7)];
      if ($urandom_range(5) == 0) op = 6'($urandom);
      f = ($urandom_range(1) == 0) ? 6'b100000 + 6'($urandom_range(10)) : 6'($urandom);
      run_instr(op, f, inst_len(op));
    end

    // Reset asserted in the middle of a lw's memory read.
    opcode = 6'b100011;
    funct  = 6'd0;
    repeat (3) @(negedge clk);
    #1 check("memrd ctl", 32'(act), 32'(expect_ctl(6'b100011, 6'd0, 3)));
    #1 rst_n = 1'b0;
    #1;
    check("mid reset outputs", 32'(act), 32'd0);
    check("mid reset instret", instret, 32'd0);
    check("mid reset illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    check("held reset regwrite", 32'(RegWrite), 32'd0);
    illegal_m = 1'b0;
    instret_m = 32'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post reset instret", instret, 32'd0);
    run_instr(6'b000000, 6'b101010, 4);

    // Counter wrap through a store.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    instret_m = 32'hFFFF_FFFF;
    run_instr(6'b101011, 6'd0, 4);
    check("instret wrap", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 No parameters; all encodings come from package mc_pkg.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction[31:26], from the instruction register.
REQ-005 funct  input  6  instruction[5:0], from the instruction register.
REQ-006 IRwrite, PCwrite, PCwritecond, IorD, MemWrite, MemRead, RegWrite, RegDst, MemtoReg, ALUSrcA  output  1 each  datapath enables and selects.
REQ-007 ALUSrcB  output  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-008 PCSrc  output  2  0=ALU result, 1=ALUOut, 2=jump target.
REQ-009 alucontrol  output  3  010=add, 110=sub, 000=and, 001=or, 111=slt.
REQ-010 branch_ne  output  1  PCwritecond qualifier: 1=take on not-zero, 0=take on zero.
REQ-011 illegal  output  1  sticky unsupported-opcode flag.
REQ-012 instret  output  32  count of retired instructions.

Function
REQ-013 Moore FSM: outputs depend only on the state register, except alucontrol, which also depends on funct.
REQ-014 FETCH: MemRead=1, IorD=0, IRwrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSrc=0, PCWrite=1; next state DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target).
REQ-016 DECODE transitions: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode -> FETCH, and illegal is set.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=2, add. Next is MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: MemRead=1, IorD=1; next MEMWB.
REQ-019 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; next FETCH.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=0, ALUOp=funct; next ALUWB.
REQ-022 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=0, sub, PCwritecond=1, PCSrc=1; next FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=2, add; next ADDIWB.
REQ-025 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-026 JUMP: PCWrite=1, PCSrc=2; next FETCH.
REQ-027 Every output not listed for a state is 0.
REQ-028 Latency in cycles, counted from FETCH: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2.
REQ-029 ALU decode for funct ops: 100000 -> add, 100010 -> sub, 100100 -> and, 100101 -> or, 101010 -> slt; any other funct gives add and sets illegal.
REQ-030 instret increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
REQ-031 instret wraps from 0xFFFFFFFF to 0.
REQ-032 The DECODE -> FETCH transition for an illegal opcode does not increment instret.
REQ-033 illegal holds once set; only rst_n clears it.

Reset
REQ-034 rst_n low forces, immediately and asynchronously: state=FETCH, illegal=0, instret=0.
REQ-035 While rst_n is low, all write enables (IRwrite, PCwrite, PCwritecond, MemWrite, RegWrite) and all other outputs read 0.
REQ-036 First FETCH outputs appear in the first cycle after rst_n deasserts.
REQ-037 Reset in mid-instruction abandons that instruction with no further write enable pulse.

Configuration
REQ-038 Macro MC_CONTROL_BNE_EN controls bne support.
REQ-039 With MC_CONTROL_BNE_EN defined: opcode 000101 -> BRANCH, and branch_ne=1 in BRANCH.
REQ-040 Without MC_CONTROL_BNE_EN: 000101 is illegal, and branch_ne is tied 0.

Structure
REQ-041 mc_pkg holds: opcode constants, funct constants, the state enum (4-bit), ALUOp codes, alucontrol codes and ALUSrcB/PCSrc select codes.
REQ-042 The ALU decode (ALUOp + funct -> alucontrol, illegal-funct strobe) is sub-module mc_aludec; the FSM, counter and flag stay in mc_control.

Verification
REQ-043 Reset release, then lw (opcode 100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 only in cycle 5; instret=1.
REQ-044 R-type with funct 101010 -> alucontrol=111 in EXECUTE; RegDst=1 and RegWrite=1 in cycle 4; instret +1.
REQ-045 beq, then j -> PCwritecond=1 with PCSrc=1 in cycle 3; then PCWrite=1 with PCSrc=2 in cycle 3; each takes 3 cycles.
REQ-046 Opcode 111111 -> return to FETCH after DECODE; illegal=1 and stays 1 through following valid instructions; instret unchanged.
REQ-047 Opcode 000101 -> with MC_CONTROL_BNE_EN: BRANCH with branch_ne=1; without it: illegal=1.
REQ-048 rst_n pulsed low in MEMRD -> outputs all 0 at once; after release, state FETCH, instret=0, no RegWrite pulse for the abandoned lw.
REQ-049 instret preloaded via force to 0xFFFFFFFF + one sw -> instret=0.
